sram_qpi_engine: RTL and testbench
==================================

// Module: sram_qpi_engine
// PURPOSE
//  Quad-SPI (QPI) transaction sequencer that drives the SRAM pin mux stage directly downstream.
//  Writes tx_len bytes, then reads rx_len bytes, as nibbles on SIO[3:0], with CS framing and a generated serial clock.
//  Outputs map onto the mux as follows: qpi_clock->auto_clock, qpi_data_out->qpi_input, qpi_oe->qpi_direction, qpi_cs->mcu_cs.
//  Input sram_sio_tdi feeds qpi_data_in.
// PARAMETERS
//  CLK_DIV  2   qpi_clock half-period in clock cycles; legal values >=1.
//  LEN_W    16  width of tx_len and rx_len.
// PORTS
//  clock         in   1      system clock; all logic on rising edge.
//  reset_n       in   1      asynchronous, active-low reset.
//  start         in   1      one-cycle request; ignored while busy=1.
//  tx_len        in   LEN_W  number of bytes to write; sampled on start.
//  rx_len        in   LEN_W  number of bytes to read; sampled on start.
//  tx_data       in   8      write byte.
//  tx_valid      in   1      tx_data is valid.
//  tx_ready      out  1      one-cycle pulse; the byte on tx_data is consumed this cycle.
//  rx_data       out  8      read byte; held until the next rx_valid.
//  rx_valid      out  1      one-cycle pulse; no backpressure.
//  busy          out  1      high from the cycle after start until done.
//  done          out  1      one-cycle pulse at transaction end.
//  qpi_cs        out  1      SRAM chip select, active-low.
//  qpi_clock     out  1      serial clock; idles low.
//  qpi_data_out  out  4      nibble driven to SIO.
//  qpi_oe        out  1      1 = engine drives SIO; 0 = SRAM drives SIO.
//  qpi_data_in   in   4      SIO sampled from the SRAM.
//  dummy_cycles  in   4      only present with SRAM_QPI_DUMMY_EN.
// BEHAVIOUR
//  Reset values: qpi_cs=1, qpi_clock=0, qpi_data_out=0, qpi_oe=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, done=0.
//  Reset is async and aborts any transaction: CS deasserts immediately and no done pulse is produced.
//  half_tick: a single-cycle strobe every CLK_DIV cycles, free-running only while busy.
//  Every phase below lasts one half-period, i.e. advances on half_tick.
//  FSM states: IDLE, CS_SETUP, TX_LO, TX_HI, DUMMY, TURN, RX_LO, RX_HI, CS_HOLD, FIN.
//  IDLE: on start with (tx_len|rx_len)!=0, latch the lengths and go to CS_SETUP.
//   - qpi_cs falls in the cycle after start.
//   - If both lengths are 0, done pulses in the cycle after start and CS never toggles.
//  CS_SETUP: qpi_clock=0. Go to TX_LO if tx_len!=0, otherwise to TURN.
//  TX_LO: qpi_oe=1, qpi_clock=0.
//   - First nibble of a byte: wait for tx_valid. Then tx_ready pulses and the byte is latched.
//   - While waiting, the phase stretches, qpi_clock stays low and the half_tick count holds.
//   - Drives bits [7:4] first, then [3:0].
//  TX_HI: qpi_clock=1, data held stable. After the 2nd nibble, decrement tx count; at 0, go to DUMMY/TURN.
//  TURN (only when rx_len!=0): qpi_oe=0 and qpi_clock=0 for one half-period. Otherwise go to CS_HOLD.
//  RX_LO: qpi_clock=0.
//  RX_HI: qpi_clock=1. qpi_data_in is captured in the clock cycle where qpi_clock rises, high nibble first.
//   - rx_valid pulses the cycle after the 2nd nibble is captured, with rx_data updated in that same cycle.
//  CS_HOLD: qpi_clock=0, qpi_oe=0, one half-period. Then qpi_cs=1 and go to FIN.
//  FIN: done=1 for one cycle, busy=0, back to IDLE.
//  Timing: one byte costs exactly 4*CLK_DIV cycles when tx_valid is never late.
//  Total duration: 2 + 4*(tx_len+rx_len) half-periods, plus 1 (TURN), plus the DUMMY phases.
//  Counters are LEN_W-bit down-counters and never wrap; a length of 2^LEN_W-1 is legal.
//  start while busy is dropped. tx_valid asserted outside TX_LO is ignored.
// CONFIGURATION
//  SRAM_QPI_DUMMY_EN defined:
//   - Adds the dummy_cycles port and the DUMMY state, entered between TX and TURN when dummy_cycles!=0.
//   - DUMMY runs dummy_cycles full qpi_clock periods with qpi_oe=0 and qpi_data_out=0.
//   - dummy_cycles is sampled on start.
//  SRAM_QPI_DUMMY_EN undefined: no port and no DUMMY state; TX goes directly to TURN/CS_HOLD.
// STRUCTURE
//  Shared header sram_qpi_defs.v, behind an include guard, holds:
//   - the FSM state localparams (4-bit encoding);
//   - the default CLK_DIV and LEN_W values.
//  One sub-module, qpi_half_tick: a CLK_DIV counter producing half_tick.
//   - It has an enable input and a stall input; the counter clears when it is disabled.
//  Everything else is flat in sram_qpi_engine.
// TESTING
//  1. CLK_DIV=2, tx_len=1, rx_len=0, tx_data=8'hA5 with tx_valid held high:
//     expect qpi_data_out 4'hA then 4'h5 with qpi_oe=1, 2 rising qpi_clock edges,
//     CS low for 12 cycles, then a single done pulse.
//  2. tx_len=0, rx_len=2, SRAM model returns 8'h3C, 8'hF0:
//     expect rx_valid twice with rx_data 8'h3C then 8'hF0, qpi_oe=0 throughout, TURN seen before the first clock.
//  3. tx_len=2 with tx_valid deasserted for 7 cycles before the 2nd byte:
//     expect qpi_clock held low, no SIO change, and exactly 2 tx_ready pulses.
//  4. Both lengths 0: expect done one cycle after start and qpi_cs never low.
//     Also pulse start again mid-transaction: expect it to be ignored.
//  5. Assert reset_n low mid-RX:
//     expect qpi_cs=1, qpi_clock=0, qpi_oe=0 asynchronously, no done pulse, and a clean next transaction.
//  6. With SRAM_QPI_DUMMY_EN and dummy_cycles=4, tx_len=1, rx_len=1:
//     expect 4 extra qpi_clock periods between the TX and RX phases with qpi_oe=0.

Source files
------------

// File: rtl/sram_qpi_engine_pkg.sv
// Shared definitions for the QPI SRAM sequencer: default sizing and the 4-bit FSM encoding.
// The DUMMY state only exists when SRAM_QPI_DUMMY_EN is defined.
package sram_qpi_engine_pkg;

  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_LEN_W   = 16;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CS_SETUP = 4'd1,
    ST_TX_LO    = 4'd2,
    ST_TX_HI    = 4'd3,
`ifdef SRAM_QPI_DUMMY_EN
    ST_DUMMY    = 4'd4,
`endif
    ST_TURN     = 4'd5,
    ST_RX_LO    = 4'd6,
    ST_RX_HI    = 4'd7,
    ST_CS_HOLD  = 4'd8,
    ST_FIN      = 4'd9
  } state_t;

endpackage

// File: rtl/sram_qpi_engine_half_tick.sv
// Half-period strobe generator for the QPI serial clock.
// Counts CLK_DIV cycles per strobe; clears while disabled and freezes while stalled.
module qpi_half_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic stall,
  output logic half_tick,
  output logic phase_first
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (!stall) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign half_tick   = enable && !stall && (count == LAST);
  // Every phase starts on a zero count, so this marks its first cycle.
  assign phase_first = (count == '0);

endmodule

// File: rtl/sram_qpi_engine.sv
// QPI transaction sequencer: writes tx_len bytes then reads rx_len bytes as nibbles under CS.
// Optional dummy clocks between write and read phases are built with SRAM_QPI_DUMMY_EN.
module sram_qpi_engine
  import sram_qpi_engine_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] tx_len,
  input  logic [LEN_W-1:0] rx_len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             qpi_cs,
  output logic             qpi_clock,
  output logic [3:0]       qpi_data_out,
  output logic             qpi_oe,
  input  logic [3:0]       qpi_data_in
`ifdef SRAM_QPI_DUMMY_EN
  ,input logic [3:0]       dummy_cycles
`endif
);

  state_t           state, state_d, after_tx, rx_or_hold;
  logic [LEN_W-1:0] tx_cnt, rx_cnt;
  logic [3:0]       tx_lo_q, rx_hi_q, sio_q;
  logic             nib, loaded, tx_wait, stall, half_tick, phase_first;
`ifdef SRAM_QPI_DUMMY_EN
  logic [3:0]       dcnt;
  logic             dphase;
`endif

  qpi_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (busy),
    .stall      (stall),
    .half_tick  (half_tick),
    .phase_first(phase_first)
  );

  // The first nibble of each byte waits for the producer; the phase freezes meanwhile.
  assign tx_wait  = (state == ST_TX_LO) && !nib && !loaded;
  assign tx_ready = tx_wait && tx_valid;
  assign stall    = tx_wait && !tx_valid;

  assign busy      = (state != ST_IDLE) && (state != ST_FIN);
  assign done      = (state == ST_FIN);
  assign qpi_cs    = !busy;
  assign qpi_oe    = (state == ST_TX_LO) || (state == ST_TX_HI);
  assign qpi_data_out = tx_ready ? tx_data[7:4] : sio_q;
`ifdef SRAM_QPI_DUMMY_EN
  assign qpi_clock = (state == ST_TX_HI) || (state == ST_RX_HI) || ((state == ST_DUMMY) && dphase);
`else
  assign qpi_clock = (state == ST_TX_HI) || (state == ST_RX_HI);
`endif

  always_comb begin
    rx_or_hold = (rx_cnt != '0) ? ST_TURN : ST_CS_HOLD;
`ifdef SRAM_QPI_DUMMY_EN
    after_tx   = (dcnt != '0) ? ST_DUMMY : rx_or_hold;
`else
    after_tx   = rx_or_hold;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:     if (start) state_d = ((tx_len != '0) || (rx_len != '0)) ? ST_CS_SETUP : ST_FIN;
      ST_CS_SETUP: if (half_tick) state_d = (tx_cnt != '0) ? ST_TX_LO : after_tx;
      ST_TX_LO:    if (half_tick) state_d = ST_TX_HI;
      ST_TX_HI:    if (half_tick) state_d = (nib && (tx_cnt == LEN_W'(1))) ? after_tx : ST_TX_LO;
`ifdef SRAM_QPI_DUMMY_EN
      ST_DUMMY:    if (half_tick && dphase && (dcnt == 4'd1)) state_d = rx_or_hold;
`endif
      ST_TURN:     if (half_tick) state_d = ST_RX_LO;
      ST_RX_LO:    if (half_tick) state_d = ST_RX_HI;
      ST_RX_HI:    if (half_tick) state_d = (nib && (rx_cnt == LEN_W'(1))) ? ST_CS_HOLD : ST_RX_LO;
      ST_CS_HOLD:  if (half_tick) state_d = ST_FIN;
      ST_FIN:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Byte counters, nibble phase, SIO drive register and read assembly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      tx_lo_q  <= '0;
      rx_hi_q  <= '0;
      sio_q    <= '0;
      nib      <= 1'b0;
      loaded   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
`ifdef SRAM_QPI_DUMMY_EN
      dcnt     <= '0;
      dphase   <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      if ((state == ST_IDLE) && start) begin
        tx_cnt <= tx_len;
        rx_cnt <= rx_len;
        nib    <= 1'b0;
        loaded <= 1'b0;
        sio_q  <= '0;
`ifdef SRAM_QPI_DUMMY_EN
        dcnt   <= dummy_cycles;
        dphase <= 1'b0;
`endif
      end
      if (tx_ready) begin
        tx_lo_q <= tx_data[3:0];
        sio_q   <= tx_data[7:4];
        loaded  <= 1'b1;
      end
      if (half_tick) begin
        case (state)
          ST_TX_HI: begin
            if (!nib) begin
              nib   <= 1'b1;
              sio_q <= tx_lo_q;
            end else begin
              nib    <= 1'b0;
              loaded <= 1'b0;
              tx_cnt <= tx_cnt - LEN_W'(1);
              if (tx_cnt == LEN_W'(1)) sio_q <= '0;
            end
          end
          ST_RX_HI: begin
            nib <= !nib;
            if (nib) rx_cnt <= rx_cnt - LEN_W'(1);
          end
`ifdef SRAM_QPI_DUMMY_EN
          ST_DUMMY: begin
            dphase <= !dphase;
            if (dphase) dcnt <= dcnt - 4'd1;
          end
`endif
          default: ;
        endcase
      end
      // Sample SIO in the cycle the serial clock rises.
      if ((state == ST_RX_HI) && phase_first) begin
        if (!nib) begin
          rx_hi_q <= qpi_data_in;
        end else begin
          rx_data  <= {rx_hi_q, qpi_data_in};
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_qpi_engine.sv
// Directed bench for sram_qpi_engine with CLK_DIV=2; the dummy-cycle case runs only with SRAM_QPI_DUMMY_EN.
// Inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
module tb_sram_qpi_engine;

  logic        clock, reset_n, start, tx_valid, tx_ready, rx_valid, busy, done;
  logic        qpi_cs, qpi_clock, qpi_oe;
  logic [15:0] tx_len, rx_len;
  logic [7:0]  tx_data, rx_data;
  logic [3:0]  qpi_data_out, qpi_data_in;
`ifdef SRAM_QPI_DUMMY_EN
  logic [3:0]  dummy_cycles;
`endif

  logic [3:0]  sram_nibs [0:15];
  logic [3:0]  nib_ptr;
  logic [3:0]  rise_data [0:15];
  logic [7:0]  rx_log [0:3];
  logic [7:0]  feed_bytes [0:1];
  logic [3:0]  prev_data;
  logic        prev_clk, start_pend, saw_ready, feed_hold;
  int          total, bad;
  int          feed_n, feed_idx, gap_len, gap_left;
  int          cs_low, oe_cycles, rises, rises_no_oe, first_rise_cs, ready_cnt, done_cnt;
  int          rx_n, low_run, max_low_run, data_changes;

  assign qpi_data_in = sram_nibs[nib_ptr];

  sram_qpi_engine #(.CLK_DIV(2), .LEN_W(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .tx_len      (tx_len),
    .rx_len      (rx_len),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .done        (done),
    .qpi_cs      (qpi_cs),
    .qpi_clock   (qpi_clock),
    .qpi_data_out(qpi_data_out),
    .qpi_oe      (qpi_oe),
    .qpi_data_in (qpi_data_in)
`ifdef SRAM_QPI_DUMMY_EN
    ,.dummy_cycles(dummy_cycles)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic setFeed(input logic [7:0] b0, input logic [7:0] b1, input int n, input int gap, input logic hold);
    feed_bytes[0] = b0;
    feed_bytes[1] = b1;
    feed_n        = n;
    gap_len       = gap;
    feed_hold     = hold;
    feed_idx      = 0;
    gap_left      = 0;
    saw_ready     = 1'b0;
  endtask

  task automatic clearMonitor();
    cs_low = 0; oe_cycles = 0; rises = 0; rises_no_oe = 0; first_rise_cs = 0;
    ready_cnt = 0; done_cnt = 0; rx_n = 0; low_run = 0; max_low_run = 0; data_changes = 0;
    nib_ptr = 4'h0;
    prev_clk = qpi_clock;
    prev_data = qpi_data_out;
  endtask

  // One clock: drive pending inputs after the rising edge, then observe on the falling edge.
  task automatic stepCycle();
    @(posedge clock);
    #1;
    start = start_pend;
    start_pend = 1'b0;
    if (saw_ready) begin
      feed_idx++;
      gap_left = gap_len;
    end else if (gap_left > 0) begin
      gap_left--;
    end
    saw_ready = 1'b0;
    if (feed_idx < feed_n) tx_data = feed_bytes[feed_idx];
    tx_valid = feed_hold || ((feed_idx < feed_n) && (gap_left == 0));
    @(negedge clock);
    if (tx_ready) begin
      saw_ready = 1'b1;
      ready_cnt++;
    end
    if (done) done_cnt++;
    if (!qpi_cs) begin
      cs_low++;
      if (qpi_oe) oe_cycles++;
    end
    if (qpi_clock && !prev_clk) begin
      if (rises < 16) rise_data[rises] = qpi_data_out;
      rises++;
      if (!qpi_oe) rises_no_oe++;
      if (rises == 1) first_rise_cs = cs_low;
    end
    if (!qpi_clock && prev_clk && nib_ptr != 4'hF) nib_ptr = nib_ptr + 4'h1;
    if (!qpi_cs && !qpi_clock) begin
      low_run++;
      if (low_run > max_low_run) max_low_run = low_run;
    end else begin
      low_run = 0;
    end
    if (qpi_data_out != prev_data) data_changes++;
    if (rx_valid && rx_n < 4) begin
      rx_log[rx_n] = rx_data;
      rx_n++;
    end
    prev_clk  = qpi_clock;
    prev_data = qpi_data_out;
  endtask

  task automatic applyStimulus(input logic [15:0] tl, input logic [15:0] rl, input int cycles);
    tx_len = tl;
    rx_len = rl;
    clearMonitor();
    start_pend = 1'b1;
    stepCycle();
    for (int i = 0; i < cycles; i++) stepCycle();
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; start = 1'b0; start_pend = 1'b0;
    tx_len = '0; rx_len = '0; tx_data = '0; tx_valid = 1'b0;
`ifdef SRAM_QPI_DUMMY_EN
    dummy_cycles = 4'd0;
`endif
    for (int i = 0; i < 16; i++) sram_nibs[i] = 4'h0;
    setFeed(8'h00, 8'h00, 0, 0, 1'b0);
    clearMonitor();
    #22;
    checkOutput("rst_cs", 32'(qpi_cs), 32'd1);
    checkOutput("rst_clk", 32'(qpi_clock), 32'd0);
    checkOutput("rst_dout", 32'(qpi_data_out), 32'd0);
    checkOutput("rst_oe", 32'(qpi_oe), 32'd0);
    checkOutput("rst_ready", 32'(tx_ready), 32'd0);
    checkOutput("rst_rxv", 32'(rx_valid), 32'd0);
    checkOutput("rst_rxd", 32'(rx_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    repeat (2) stepCycle();

    // Single write byte A5 with tx_valid held high throughout.
    setFeed(8'hA5, 8'hA5, 1, 0, 1'b1);
    applyStimulus(16'd1, 16'd0, 20);
    checkOutput("t1_cs_low", 32'(cs_low), 32'd12);
    checkOutput("t1_rises", 32'(rises), 32'd2);
    checkOutput("t1_nib_hi", 32'(rise_data[0]), 32'hA);
    checkOutput("t1_nib_lo", 32'(rise_data[1]), 32'h5);
    checkOutput("t1_oe", 32'(oe_cycles), 32'd8);
    checkOutput("t1_ready", 32'(ready_cnt), 32'd1);
    checkOutput("t1_done", 32'(done_cnt), 32'd1);
    setFeed(8'h00, 8'h00, 0, 0, 1'b0);
    stepCycle();

    // Read-only, two bytes 3C and F0 from the SRAM model.
    sram_nibs[0] = 4'h3; sram_nibs[1] = 4'hC; sram_nibs[2] = 4'hF; sram_nibs[3] = 4'h0;
    applyStimulus(16'd0, 16'd2, 30);
    checkOutput("t2_rx_cnt", 32'(rx_n), 32'd2);
    checkOutput("t2_rx0", 32'(rx_log[0]), 32'h3C);
    checkOutput("t2_rx1", 32'(rx_log[1]), 32'hF0);
    checkOutput("t2_oe", 32'(oe_cycles), 32'd0);
    checkOutput("t2_turn", 32'(first_rise_cs), 32'd7);
    checkOutput("t2_cs_low", 32'(cs_low), 32'd22);
    checkOutput("t2_done", 32'(done_cnt), 32'd1);
    checkOutput("t2_hold", 32'(rx_data), 32'hF0);

    // Two write bytes, the second held back so its TX_LO phase stalls 7 cycles.
    setFeed(8'h12, 8'h34, 2, 14, 1'b0);
    applyStimulus(16'd2, 16'd0, 35);
    checkOutput("t3_ready", 32'(ready_cnt), 32'd2);
    checkOutput("t3_rises", 32'(rises), 32'd4);
    checkOutput("t3_n0", 32'(rise_data[0]), 32'h1);
    checkOutput("t3_n1", 32'(rise_data[1]), 32'h2);
    checkOutput("t3_n2", 32'(rise_data[2]), 32'h3);
    checkOutput("t3_n3", 32'(rise_data[3]), 32'h4);
    checkOutput("t3_low_run", 32'(max_low_run), 32'd9);
    checkOutput("t3_sio_chg", 32'(data_changes), 32'd5);
    checkOutput("t3_cs_low", 32'(cs_low), 32'd27);
    setFeed(8'h00, 8'h00, 0, 0, 1'b0);

    // Zero-length request, then a start pulse during a busy read.
    applyStimulus(16'd0, 16'd0, 1);
    checkOutput("t4_done_t1", 32'(done), 32'd1);
    for (int i = 0; i < 5; i++) stepCycle();
    checkOutput("t4_cs_low", 32'(cs_low), 32'd0);
    checkOutput("t4_done", 32'(done_cnt), 32'd1);
    applyStimulus(16'd0, 16'd1, 4);
    tx_len = 16'd1;
    rx_len = 16'd1;
    start_pend = 1'b1;
    for (int i = 0; i < 20; i++) stepCycle();
    checkOutput("t4_busy_cs", 32'(cs_low), 32'd14);
    checkOutput("t4_busy_done", 32'(done_cnt), 32'd1);
    checkOutput("t4_busy_rx", 32'(rx_n), 32'd1);

    // Asynchronous reset while the serial clock is high in the read phase.
    applyStimulus(16'd0, 16'd2, 8);
    checkOutput("t5_pre_clk", 32'(qpi_clock), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t5_cs", 32'(qpi_cs), 32'd1);
    checkOutput("t5_clk", 32'(qpi_clock), 32'd0);
    checkOutput("t5_oe", 32'(qpi_oe), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    clearMonitor();
    for (int i = 0; i < 3; i++) stepCycle();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) stepCycle();
    checkOutput("t5_no_done", 32'(done_cnt), 32'd0);
    checkOutput("t5_no_cs", 32'(cs_low), 32'd0);
    checkOutput("t5_no_rxv", 32'(rx_n), 32'd0);
    setFeed(8'h5A, 8'h00, 1, 0, 1'b0);
    applyStimulus(16'd1, 16'd0, 20);
    checkOutput("t5_re_cs", 32'(cs_low), 32'd12);
    checkOutput("t5_re_hi", 32'(rise_data[0]), 32'h5);
    checkOutput("t5_re_lo", 32'(rise_data[1]), 32'hA);
    checkOutput("t5_re_done", 32'(done_cnt), 32'd1);
    setFeed(8'h00, 8'h00, 0, 0, 1'b0);

`ifdef SRAM_QPI_DUMMY_EN
    // Write one byte, four dummy clocks, read one byte (captured at nibble slots 6 and 7).
    sram_nibs[6] = 4'hE; sram_nibs[7] = 4'h7;
    dummy_cycles = 4'd4;
    setFeed(8'h96, 8'h00, 1, 0, 1'b0);
    applyStimulus(16'd1, 16'd1, 45);
    checkOutput("t6_rises", 32'(rises), 32'd8);
    checkOutput("t6_rises_in", 32'(rises_no_oe), 32'd6);
    checkOutput("t6_oe", 32'(oe_cycles), 32'd8);
    checkOutput("t6_cs_low", 32'(cs_low), 32'd38);
    checkOutput("t6_rx", 32'(rx_log[0]), 32'hE7);
    checkOutput("t6_done", 32'(done_cnt), 32'd1);
    dummy_cycles = 4'd0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
